array_serializer: RTL

ARRAY_SERIALIZER -- requirements
Module: array_serializer

---
 rtl/array_serializer_pkg.sv | 14 +
 rtl/array_serializer.sv | 118 +++++++++++
 2 files changed

// File: rtl/array_serializer_pkg.sv
// Shared types and helpers for array_serializer.
package array_serializer_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  // Index port width; a single-element array still needs a 1-bit index.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/array_serializer.sv
// Captures a parallel vector and replays it one element per handshake.
// Optional running-sum output enabled by defining ARRAY_SERIALIZER_SUM_EN.
module array_serializer
  import array_serializer_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_INPUTS = 8,
  localparam int IDX_WIDTH = idx_width(NUM_INPUTS)
`ifdef ARRAY_SERIALIZER_SUM_EN
  ,
  localparam int SUM_WIDTH = DATA_WIDTH + $clog2(NUM_INPUTS)
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in [NUM_INPUTS],
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out,
  output logic [IDX_WIDTH-1:0]  out_index,
  output logic                  out_last
`ifdef ARRAY_SERIALIZER_SUM_EN
  ,
  output logic [SUM_WIDTH-1:0]  sum
`endif
);

  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_INPUTS - 1);

  state_e                state_q, state_d;
  logic [IDX_WIDTH-1:0]  idx_q, idx_d;
  logic [DATA_WIDTH-1:0] buf_q [NUM_INPUTS];
  logic [DATA_WIDTH-1:0] buf_d [NUM_INPUTS];
  logic                  out_valid_q, out_valid_d;
  logic                  out_last_q, out_last_d;
  logic [DATA_WIDTH-1:0] out_q, out_d;
  logic                  accept, beat, load;

  // A new vector is taken while idle, or on the final beat for zero-bubble streaming.
  assign in_ready = !rst && ((state_q == IDLE) || (out_ready && out_last_q));

  always_comb begin
    beat    = out_valid_q && out_ready;
    accept  = in_valid && in_ready;
    state_d = state_q;
    idx_d   = idx_q;
    buf_d   = buf_q;
    load    = 1'b0;
    if (accept) begin
      buf_d   = in;
      idx_d   = '0;
      state_d = SEND;
      load    = 1'b1;
    end else if (beat) begin
      if (out_last_q) begin
        state_d = IDLE;
        idx_d   = '0;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
    // Outputs are precomputed from next state so they come straight from flops.
    out_valid_d = (state_d == SEND);
    out_d       = out_valid_d ? buf_d[idx_d] : '0;
    out_last_d  = out_valid_d && (idx_d == LAST_IDX);
  end

`ifdef ARRAY_SERIALIZER_SUM_EN
  logic [SUM_WIDTH-1:0] sum_q, sum_d;

  always_comb begin
    sum_d = sum_q;
    if (!out_valid_d) begin
      sum_d = '0;
    end else if (load) begin
      sum_d = SUM_WIDTH'(out_d);
    end else if (beat) begin
      sum_d = sum_q + SUM_WIDTH'(out_d);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign sum = sum_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      buf_q       <= '{default: '0};
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_q       <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      buf_q       <= buf_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_q       <= out_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out       = out_q;
  assign out_index = idx_q;

endmodule
